// File: rtl/sram_uart_dump_pkg.sv
// rtl/sram_uart_dump_pkg.sv - dump FSM state encoding and the 50 MHz / 115200 baud divider default
package sram_uart_dump_pkg;

    localparam int BAUD_DIV_DEFAULT = 434;

    typedef enum logic [3:0] {
        S_DUMP_IDLE,
        S_DUMP_ISSUE,
        S_DUMP_WAIT_0,
        S_DUMP_WAIT_1,
        S_DUMP_LATCH,
        S_DUMP_SEND_HI,
        S_DUMP_SEND_LO,
        S_DUMP_CSUM_HI,
        S_DUMP_CSUM_LO,
        S_DUMP_FINISH
    } dump_state_type;

endpackage

// File: rtl/sram_uart_dump_tx.sv
// rtl/sram_uart_dump_tx.sv - uart_tx_byte: 8N1 serialiser, Load pulse in, Tx_done in last stop-bit cycle
module uart_tx_byte
    import sram_uart_dump_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       Clock_50,
    input  logic       Reset,
    input  logic       Load,
    input  logic [7:0] Data,
    output logic       UART_TX_O,
    output logic       Tx_done
);

    localparam int              CW       = $clog2(BAUD_DIV);
    localparam logic [CW-1:0]   CNT_LAST = CW'(BAUD_DIV - 1);

    logic          active;
    logic [CW-1:0] cnt;
    logic [3:0]    idx;
    logic [7:0]    data_q;
    logic          bit_end;

    // idx 0 is the start bit, 1..8 the data bits, 9 the stop bit
    assign bit_end = (cnt == CNT_LAST);
    assign Tx_done = active && bit_end && (idx == 4'd9);

    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            active    <= 1'b0;
            cnt       <= '0;
            idx       <= '0;
            data_q    <= '0;
            UART_TX_O <= 1'b1;
        end else if (Load) begin
            active    <= 1'b1;
            cnt       <= '0;
            idx       <= '0;
            data_q    <= Data;
            UART_TX_O <= 1'b0;
        end else if (active) begin
            if (bit_end) begin
                cnt <= '0;
                if (idx == 4'd9) begin
                    active <= 1'b0;
                end else begin
                    idx       <= idx + 4'd1;
                    UART_TX_O <= (idx == 4'd8) ? 1'b1 : data_q[idx[2:0]];
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sram_uart_dump.sv
// rtl/sram_uart_dump.sv - SRAM region dump over UART 8N1, high byte first; DUMP_CHECKSUM_EN appends a 16-bit word sum
module sram_uart_dump
    import sram_uart_dump_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic        Clock_50,
    input  logic        Reset,
    input  logic        Start,
    input  logic [17:0] Base_address,
    input  logic [17:0] Length,
    output logic [17:0] SRAM_address,
    output logic        SRAM_we_n,
    input  logic [15:0] SRAM_read_data,
    output logic        UART_TX_O,
    output logic        Busy,
    output logic        Done
);

`ifdef DUMP_CHECKSUM_EN
    localparam dump_state_type S_AFTER_DATA = S_DUMP_CSUM_HI;
    logic [15:0] csum;
`else
    localparam dump_state_type S_AFTER_DATA = S_DUMP_FINISH;
`endif

    dump_state_type state, state_n;
    logic [17:0] words_left;
    logic [15:0] word_q;
    logic        load_q;
    logic        load;
    logic [7:0]  tx_data;
    logic        tx_done;

    always_comb begin
        state_n = state;
        case (state)
            S_DUMP_IDLE:    if (Start) state_n = (Length == '0) ? S_AFTER_DATA : S_DUMP_ISSUE;
            S_DUMP_ISSUE:   state_n = S_DUMP_WAIT_0;
            S_DUMP_WAIT_0:  state_n = S_DUMP_WAIT_1;
            S_DUMP_WAIT_1:  state_n = S_DUMP_LATCH;
            S_DUMP_LATCH:   state_n = S_DUMP_SEND_HI;
            S_DUMP_SEND_HI: if (tx_done) state_n = S_DUMP_SEND_LO;
            S_DUMP_SEND_LO: if (tx_done) state_n = (words_left == 18'd1) ? S_AFTER_DATA : S_DUMP_ISSUE;
`ifdef DUMP_CHECKSUM_EN
            S_DUMP_CSUM_HI: if (tx_done) state_n = S_DUMP_CSUM_LO;
            S_DUMP_CSUM_LO: if (tx_done) state_n = S_DUMP_FINISH;
`endif
            S_DUMP_FINISH:  state_n = S_DUMP_IDLE;
            default:        state_n = S_DUMP_IDLE;
        endcase
    end

    // The high byte goes straight from the SRAM bus in LATCH so its start bit
    // lands in the first SEND_HI cycle; later bytes load one cycle after entry.
    always_comb begin
        tx_data = word_q[7:0];
        case (state)
            S_DUMP_LATCH:   tx_data = SRAM_read_data[15:8];
`ifdef DUMP_CHECKSUM_EN
            S_DUMP_CSUM_HI: tx_data = csum[15:8];
            S_DUMP_CSUM_LO: tx_data = csum[7:0];
`endif
            default:        tx_data = word_q[7:0];
        endcase
    end

    assign load      = (state == S_DUMP_LATCH) || load_q;
    assign Busy      = (state != S_DUMP_IDLE);
    assign SRAM_we_n = 1'b1;

    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            state        <= S_DUMP_IDLE;
            SRAM_address <= '0;
            words_left   <= '0;
            word_q       <= '0;
            load_q       <= 1'b0;
            Done         <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            state  <= state_n;
            load_q <= (state_n != state) &&
                      (state_n inside {S_DUMP_SEND_LO, S_DUMP_CSUM_HI, S_DUMP_CSUM_LO});
            Done   <= (state == S_DUMP_FINISH);
            if (state == S_DUMP_IDLE && Start) begin
                words_left <= Length;
                // the address only moves when a read will really be issued
                if (Length != '0) SRAM_address <= Base_address;
`ifdef DUMP_CHECKSUM_EN
                csum <= '0;
`endif
            end
            if (state == S_DUMP_LATCH) begin
                word_q <= SRAM_read_data;
`ifdef DUMP_CHECKSUM_EN
                csum   <= csum + SRAM_read_data;
`endif
            end
            if (state == S_DUMP_SEND_LO && tx_done) begin
                words_left <= words_left - 18'd1;
                if (words_left != 18'd1) SRAM_address <= SRAM_address + 18'd1;
            end
        end
    end

    uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) u_tx (
        .Clock_50  (Clock_50),
        .Reset     (Reset),
        .Load      (load),
        .Data      (tx_data),
        .UART_TX_O (UART_TX_O),
        .Tx_done   (tx_done)
    );

endmodule
